opb_register_ppc2user_bank: RTL and testbench
=============================================

# opb_register_ppc2user_bank

OPB slave holding a bank of PowerPC-writable control registers that drive user fabric logic, with readback and per-register write strobes. It is the write-direction counterpart of the simulink-to-PPC status registers and sits on the same OPB segment. User logic runs on OPB_Clk, so there is no clock-domain crossing. Each accepted write updates one 32-bit register, honouring byte enables, and pulses that register's strobe for exactly one cycle.

## Interface
- C_BASEADDR, 32'h00000000, first byte address of the slave window.
- C_HIGHADDR, 32'h000000FF, last byte address of the window; size ≥ 4*C_NUM_REGS.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_NUM_REGS, 4, number of registers (1..16).
- C_RESET_VAL, 32'h00000000, reset value of every register.
- C_FAMILY, "virtex6", target family (informational).

Ports:
- OPB_Clk  in  1  single clock for bus and user side.
- OPB_Rst  in  1  reset; asynchronous, active-high.
- OPB_ABus  in  [0:31]  byte address.
- OPB_BE  in  [0:3]  byte enables; BE[0] qualifies DBus[0:7].
- OPB_DBus  in  [0:31]  write data, bit 0 = MSB.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero except during a read ack.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
- user_data_out  out  [32*C_NUM_REGS-1:0]  register contents; reg k occupies bits [32k+31:32k].
- user_wr_strobe  out  [C_NUM_REGS-1:0]  one-cycle pulse per accepted write to reg k.

## Operation
- **Hit:** OPB_select=1, C_BASEADDR ≤ OPB_ABus ≤ C_HIGHADDR, and ack_block=0.
- **Register index:** (OPB_ABus−C_BASEADDR)[5:2].
- **Slot states:** IDLE → ACK on hit → BLOCK → IDLE.
  - ACK: Sl_xferAck=1 for one cycle.
  - BLOCK: one cycle in which no new hit is accepted, so a select held through ack is not double-acked.
- **Write hit:** in the ACK cycle, reg[index] byte b takes DBus[8b:8b+7] wherever BE[b]=1. Bytes with BE=0 hold their value.
- **Write strobe:** user_wr_strobe[index] pulses in the ACK cycle even when BE=0000.
- **Read hit:** Sl_DBus = reg[index] during the ACK cycle. Register bit 31 maps to DBus[0].
- **Out-of-bank index:** index ≥ C_NUM_REGS inside the window is still acked. Reads return 0; writes change nothing and pulse no strobe.
- **Miss:** an address outside the window is never acked, and Sl_DBus stays 0.
- **Bus state:** write data, BE, index and RNW are captured at the hit edge and used in the ACK cycle.

## Timing
- Reset values:
  - reg = C_RESET_VAL.
  - Sl_DBus, Sl_xferAck and user_wr_strobe = 0.
  - State = IDLE.
- **Latency:** hit sampled at edge N; Sl_xferAck and Sl_DBus are high/valid during cycle N+1.
- **Register visibility:** the new register value appears on user_data_out from edge N+1, coincident with the strobe.
- **Back-to-back:** minimum spacing between acks is 2 cycles (ACK, BLOCK); a continuously asserted select gives an ack every other cycle.
- **Outputs:** all registered; no combinational path from OPB inputs to any output.
- **Reset mid-transfer:** an asynchronous OPB_Rst during ACK drops Sl_xferAck and strobes immediately. The pending write is lost and registers return to C_RESET_VAL.
- **Read after write:** a read of the same register acked in the cycle after BLOCK returns the newly written value.

## Test plan
- **Reset:** assert OPB_Rst with C_RESET_VAL=32'hA5A50000 → all user_data_out words = A5A50000, Sl_xferAck=0, Sl_DBus=0.
- **Full write:** write 32'hDEADBEEF, BE=1111, to base+4 → ack one cycle after select; user_data_out[63:32]=DEADBEEF; user_wr_strobe=0010 for one cycle; readback returns DEADBEEF.
- **Byte enables:** with reg0=DEADBEEF, write 32'h11223344 with BE=0101 → reg0=DE22BE44; strobe[0] pulses.
- **Out-of-bank and miss:** write to base+0x20 (index 8) with C_NUM_REGS=4 → ack, no register change, no strobe; read returns 0. Access to C_HIGHADDR+4 → no ack for 16 cycles.
- **Held select:** select held 6 cycles on a read → exactly 3 acks, each followed by a zero-ack cycle; Sl_DBus nonzero only in ack cycles.
- **Reset during ack:** OPB_Rst asserted in the ACK cycle of a write of 0x12345678 → ack and strobe fall in the same cycle; register = C_RESET_VAL after release.

Source files
------------

// File: rtl/opb_register_ppc2user_bank.sv
`default_nettype none
// ============================================================================
// Module   : opb_register_ppc2user_bank
// Purpose  : OPB slave holding a bank of PowerPC-writable 32-bit control
//            registers that drive user fabric logic. Writes honour byte
//            enables and pulse a one-cycle strobe for the register written;
//            reads return the register contents. Bus and user logic share
//            OPB_Clk, so there is no clock-domain crossing.
// Ports    : OPB_Clk/OPB_Rst        clock, asynchronous active-high reset
//            OPB_ABus/BE/DBus/RNW   OPB request (big-endian bit numbering)
//            OPB_select/seqAddr     transfer request / burst hint (ignored)
//            Sl_DBus/Sl_xferAck     registered read data and acknowledge
//            Sl_errAck/retry/toutSup tied low
//            user_data_out          register k at bits [32k+31:32k]
//            user_wr_strobe         one-cycle pulse per accepted write
// Revision : 1.0  initial release
// ============================================================================
module opb_register_ppc2user_bank #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter logic [31:0] C_RESET_VAL  = 32'h0000_0000,
    parameter              C_FAMILY     = "virtex6"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0]  user_data_out,
    output logic [C_NUM_REGS-1:0]     user_wr_strobe
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_BLOCK = 2'd2
    } state_t;

    localparam logic [31:0] c_win_span = C_HIGHADDR - C_BASEADDR;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [32:0]          w_diff;
    logic                 w_in_window;
    logic                 w_ack_block;
    logic                 w_hit;
    logic                 w_wr_hit;
    logic [3:0]           w_idx;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic [C_NUM_REGS-1:0] w_sel;
    logic [31:0]          w_rd_data;
    logic [31:0]          r_sl_dbus;
    logic [C_NUM_REGS-1:0] r_wr_strobe;

    // Bus vectors use bit 0 = MSB; assigning them to [n:0] vectors keeps
    // the numeric value, so byte lane BE[0] lands on w_be[3] / bits 31:24.
    assign w_be    = OPB_BE;
    assign w_wdata = OPB_DBus;

    // A 33-bit subtraction gives both the window lower bound (no borrow)
    // and the offset used for the upper bound and the register index.
    assign w_diff      = {1'b0, OPB_ABus} - {1'b0, C_BASEADDR};
    assign w_in_window = !w_diff[32] && (w_diff[31:0] <= c_win_span);
    assign w_idx       = w_diff[5:2];

    // The master still holds select during the ACK cycle; refusing a hit at
    // the edge that ends ACK prevents a double acknowledge.
    assign w_ack_block = (r_state == ST_ACK);
    assign w_hit       = OPB_select && w_in_window && !w_ack_block;
    assign w_wr_hit    = w_hit && !OPB_RNW;

    // ------------------------------------------------------------------
    // Transfer slot FSM
    // ------------------------------------------------------------------
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_hit) w_state_nxt = ST_ACK;
            ST_ACK:   w_state_nxt = ST_BLOCK;
            ST_BLOCK: w_state_nxt = w_hit ? ST_ACK : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Register bank. An index outside the bank matches no w_sel bit, so
    // such writes change nothing and reads of it return zero.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_reg
        logic [31:0] r_reg;

        assign w_sel[k] = (w_idx == 4'(k));

        always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
            if (OPB_Rst) begin
                r_reg <= C_RESET_VAL;
            end else if (w_wr_hit && w_sel[k]) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        r_reg[8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
            end
        end

        assign user_data_out[32*k +: 32] = r_reg;
    end

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            if (w_sel[k]) begin
                w_rd_data = user_data_out[32*k +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered bus outputs: read data and strobes are loaded at the hit
    // edge and therefore valid exactly during the ACK cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_sl_dbus   <= '0;
            r_wr_strobe <= '0;
        end else begin
            r_sl_dbus   <= (w_hit && OPB_RNW) ? w_rd_data : 32'h0;
            r_wr_strobe <= w_wr_hit ? w_sel : '0;
        end
    end

    assign Sl_DBus        = r_sl_dbus;
    assign Sl_xferAck     = (r_state == ST_ACK);
    assign Sl_errAck      = 1'b0;
    assign Sl_retry       = 1'b0;
    assign Sl_toutSup     = 1'b0;
    assign user_wr_strobe = r_wr_strobe;

    // Address bits outside the index field and the burst hint carry no
    // meaning for this slave.
    logic w_unused;
    assign w_unused = &{1'b0, OPB_seqAddr, w_diff[31:6], w_diff[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_opb_register_ppc2user_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_opb_register_ppc2user_bank
// Purpose  : Self-checking bench for opb_register_ppc2user_bank: directed
//            vector table, multi-cycle corner sequences and randomized
//            accesses checked against a behavioural register-bank model.
// Revision : 1.0  initial release
// ============================================================================
module tb_opb_register_ppc2user_bank;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] HIGH = 32'h0000_10FF;
    localparam logic [31:0] RVAL = 32'hA5A5_0000;
    localparam int          NREG = 4;
    localparam int          UW   = 32 * NREG;

    logic            clk;
    logic            rst;
    logic [0:31]     abus;
    logic [0:3]      be;
    logic [0:31]     dbus;
    logic            rnw;
    logic            sel;
    logic            seq_addr;
    logic [0:31]     sl_dbus;
    logic            sl_ack;
    logic            sl_err;
    logic            sl_retry;
    logic            sl_tout;
    logic [UW-1:0]   udo;
    logic [NREG-1:0] stb;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [NREG];

    opb_register_ppc2user_bank #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_NUM_REGS   (NREG),
        .C_RESET_VAL  (RVAL),
        .C_FAMILY     ("virtex6")
    ) dut (
        .OPB_Clk        (clk),
        .OPB_Rst        (rst),
        .OPB_ABus       (abus),
        .OPB_BE         (be),
        .OPB_DBus       (dbus),
        .OPB_RNW        (rnw),
        .OPB_select     (sel),
        .OPB_seqAddr    (seq_addr),
        .Sl_DBus        (sl_dbus),
        .Sl_xferAck     (sl_ack),
        .Sl_errAck      (sl_err),
        .Sl_retry       (sl_retry),
        .Sl_toutSup     (sl_tout),
        .user_data_out  (udo),
        .user_wr_strobe (stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string name, int tag, logic [UW-1:0] act, logic [UW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h expected %h", name, tag, act, exp);
        end
    endfunction

    function automatic logic [UW-1:0] model_udo();
        logic [UW-1:0] v = '0;
        for (int k = 0; k < NREG; k++) v[32*k +: 32] = model[k];
        return v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NREG; k++) model[k] = RVAL;
    endfunction

    // Behavioural view: window test and index by plain arithmetic, byte
    // lane L (0 = most significant byte) enabled by the L-th BE bit.
    function automatic void model_access(input logic r, input logic [31:0] a,
                                         input logic [3:0] e, input logic [31:0] d,
                                         output bit x_ack, output logic [31:0] x_rd,
                                         output logic [3:0] x_stb);
        int idx;
        logic [31:0] mask;
        x_ack = (a >= BASE) && (a <= HIGH);
        x_rd  = 32'h0;
        x_stb = 4'h0;
        if (x_ack) begin
            idx = int'((a - BASE) / 4) % 16;
            if (idx < NREG) begin
                if (r) begin
                    x_rd = model[idx];
                end else begin
                    mask = 32'h0;
                    for (int lane = 0; lane < 4; lane++)
                        if (((e >> (3 - lane)) & 4'h1) != 0)
                            mask = mask | (32'hFF << (24 - 8 * lane));
                    model[idx] = (model[idx] & ~mask) | (d & mask);
                    x_stb = 4'(1 << idx);
                end
            end
        end
    endfunction

    // Issues one transfer from a negedge; returns after the post-ack cycle.
    task automatic xfer(input logic r, input logic [31:0] a, input logic [3:0] e,
                        input logic [31:0] d, output bit acked, output logic [31:0] rd,
                        output logic [3:0] s, output logic [UW-1:0] u, output bit stray);
        int n = 0;
        acked = 0; rd = '0; s = '0; u = '0; stray = 0;
        sel = 1'b1; rnw = r; abus = a; be = e; dbus = d;
        while (!acked && n < 16) begin
            @(negedge clk);
            n++;
            if (sl_ack) begin
                acked = 1; rd = sl_dbus; s = stb; u = udo;
            end else if (sl_dbus != 0 || stb != 0) begin
                stray = 1;
            end
        end
        sel = 1'b0; rnw = 1'b0; abus = '0; be = '0; dbus = '0;
        if (acked) begin
            @(negedge clk);
            if (sl_ack || sl_dbus != 0 || stb != 0) stray = 1;
        end
    endtask

    task automatic run_vec(string name, int tag, input logic r, input logic [31:0] a,
                           input logic [3:0] e, input logic [31:0] d, input bit x_ack,
                           input logic [31:0] x_rd, input logic [3:0] x_stb);
        bit acked, stray, m_ack;
        logic [31:0] rd, m_rd;
        logic [3:0] s, m_stb;
        logic [UW-1:0] u;
        model_access(r, a, e, d, m_ack, m_rd, m_stb);
        xfer(r, a, e, d, acked, rd, s, u, stray);
        chk({name, "_ack"}, tag, UW'(acked), UW'(x_ack));
        chk({name, "_rdata"}, tag, UW'(rd), UW'(x_rd));
        chk({name, "_strobe"}, tag, UW'(s), UW'(x_stb));
        chk({name, "_stray"}, tag, UW'(stray), '0);
        if (x_ack) chk({name, "_udo_at_ack"}, tag, u, model_udo());
        chk({name, "_udo_after"}, tag, udo, model_udo());
    endtask

    typedef struct {
        logic        r;
        logic [31:0] a;
        logic [3:0]  e;
        logic [31:0] d;
        bit          x_ack;
        logic [31:0] x_rd;
        logic [3:0]  x_stb;
    } vec_t;

    vec_t tbl [15];

    initial begin
        bit          acked;
        int          nack;
        logic [31:0] a;
        bit          m_ack;
        logic [31:0] m_rd;
        logic [3:0]  m_stb;

        tbl[0]  = '{1'b0, BASE + 32'h04, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0,        4'b0010};
        tbl[1]  = '{1'b1, BASE + 32'h04, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF, 4'b0000};
        tbl[2]  = '{1'b0, BASE + 32'h00, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0,        4'b0001};
        tbl[3]  = '{1'b0, BASE + 32'h00, 4'b0101, 32'h11223344, 1'b1, 32'h0,        4'b0001};
        tbl[4]  = '{1'b1, BASE + 32'h00, 4'b0000, 32'h0,        1'b1, 32'hDE22BE44, 4'b0000};
        tbl[5]  = '{1'b0, BASE + 32'h20, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0,        4'b0000};
        tbl[6]  = '{1'b1, BASE + 32'h20, 4'b1111, 32'h0,        1'b1, 32'h0,        4'b0000};
        tbl[7]  = '{1'b0, BASE + 32'h08, 4'b0000, 32'h12345678, 1'b1, 32'h0,        4'b0100};
        tbl[8]  = '{1'b1, BASE + 32'h0B, 4'b1111, 32'h0,        1'b1, 32'hA5A50000, 4'b0000};
        tbl[9]  = '{1'b1, BASE + 32'h0C, 4'b1111, 32'h0,        1'b1, 32'hA5A50000, 4'b0000};
        tbl[10] = '{1'b0, HIGH + 32'h04, 4'b1111, 32'h0BADF00D, 1'b0, 32'h0,        4'b0000};
        tbl[11] = '{1'b1, BASE - 32'h04, 4'b1111, 32'h0,        1'b0, 32'h0,        4'b0000};
        tbl[12] = '{1'b0, BASE + 32'hFC, 4'b1111, 32'h55555555, 1'b1, 32'h0,        4'b0000};
        tbl[13] = '{1'b0, BASE + 32'h0C, 4'b1000, 32'h77000000, 1'b1, 32'h0,        4'b1000};
        tbl[14] = '{1'b1, BASE + 32'h0C, 4'b0000, 32'h0,        1'b1, 32'h77A50000, 4'b0000};

        rst = 1'b1; sel = 1'b0; rnw = 1'b0; abus = '0; be = '0; dbus = '0; seq_addr = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_udo", 0, udo, {NREG{RVAL}});
        chk("reset_ack", 0, UW'(sl_ack), '0);
        chk("reset_dbus", 0, UW'(sl_dbus), '0);
        chk("reset_strobe", 0, UW'(stb), '0);
        chk("reset_tieoffs", 0, UW'({sl_err, sl_retry, sl_tout}), '0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_udo_after", 0, udo, {NREG{RVAL}});

        // Directed table, issued back to back
        for (int i = 0; i < 15; i++)
            run_vec("vec", i, tbl[i].r, tbl[i].a, tbl[i].e, tbl[i].d,
                    tbl[i].x_ack, tbl[i].x_rd, tbl[i].x_stb);

        // Select held for six cycles on a read of reg1 (DEADBEEF)
        sel = 1'b1; rnw = 1'b1; abus = BASE + 32'h04; be = 4'b1111;
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sl_ack) nack++;
            chk("held_ack", i, UW'(sl_ack), UW'((i % 2) == 0));
            chk("held_dbus", i, UW'(sl_dbus), UW'(((i % 2) == 0) ? 32'hDEADBEEF : 32'h0));
        end
        sel = 1'b0; rnw = 1'b0; abus = '0; be = '0;
        @(negedge clk);
        chk("held_ack_end", 0, UW'(sl_ack), '0);
        chk("held_ack_count", 0, UW'(nack), UW'(3));

        // Reset asserted in the ACK cycle of a write
        sel = 1'b1; rnw = 1'b0; abus = BASE + 32'h0C; be = 4'b1111; dbus = 32'h12345678;
        acked = 0;
        for (int n = 0; n < 4 && !acked; n++) begin
            @(negedge clk);
            if (sl_ack) acked = 1;
        end
        chk("rst_ack_seen", 0, UW'(acked), UW'(1));
        chk("rst_strobe_seen", 0, UW'(stb), UW'(4'b1000));
        rst = 1'b1;
        #1;
        chk("rst_ack_drop", 0, UW'(sl_ack), '0);
        chk("rst_strobe_drop", 0, UW'(stb), '0);
        chk("rst_dbus", 0, UW'(sl_dbus), '0);
        sel = 1'b0; abus = '0; be = '0; dbus = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_udo_after", 0, udo, model_udo());

        // Randomized accesses against the model
        for (int i = 0; i < 80; i++) begin
            int sel_kind = $urandom_range(0, 9);
            logic r = 1'($urandom_range(0, 1));
            logic [3:0] e = 4'($urandom);
            logic [31:0] d = $urandom;
            if (sel_kind == 0)
                a = ($urandom_range(0, 1) == 0) ? BASE - 32'(1 + $urandom_range(0, 255))
                                                : HIGH + 32'(1 + $urandom_range(0, 255));
            else if (sel_kind < 7)
                a = BASE + 32'($urandom_range(0, 15));
            else
                a = BASE + 32'($urandom_range(0, 255));
            begin
                logic [31:0] save [NREG];
                for (int k = 0; k < NREG; k++) save[k] = model[k];
                model_access(r, a, e, d, m_ack, m_rd, m_stb);
                for (int k = 0; k < NREG; k++) model[k] = save[k];
            end
            run_vec("rand", i, r, a, e, d, m_ack, m_rd, m_stb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
